// File: rtl/bus_dma_host.sv
// Single-channel word-copy DMA host: a device-side register window plus a host port
// that copies LEN 32-bit words from SRC to DST, raising a level interrupt when done.
module bus_dma_host #(
    parameter int RegOffsetWidth = 10,
    parameter int LenWidth       = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_addr_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        dma_irq_o
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    localparam logic [RegOffsetWidth-1:0] OFF_SRC    = RegOffsetWidth'('h00);
    localparam logic [RegOffsetWidth-1:0] OFF_DST    = RegOffsetWidth'('h04);
    localparam logic [RegOffsetWidth-1:0] OFF_LEN    = RegOffsetWidth'('h08);
    localparam logic [RegOffsetWidth-1:0] OFF_CTRL   = RegOffsetWidth'('h0C);
    localparam logic [RegOffsetWidth-1:0] OFF_STATUS = RegOffsetWidth'('h10);
    localparam logic [RegOffsetWidth-1:0] OFF_REMAIN = RegOffsetWidth'('h14);

    state_t                state_reg, state_next;
    logic [31:0]           src_reg, src_next, dst_reg, dst_next;
    logic [LenWidth-1:0]   len_reg, len_next, remain_reg, remain_next;
    logic                  irq_en_reg, irq_en_next, done_reg, done_next, err_reg, err_next;
    logic [31:0]           work_src_reg, work_src_next, work_dst_reg, work_dst_next;
    logic [31:0]           data_reg, data_next;
    logic                  host_req_reg, host_req_next, host_we_reg, host_we_next;
    logic [31:0]           host_addr_reg, host_addr_next, host_wdata_reg, host_wdata_next;
    logic                  dev_rvalid_reg, dev_err_reg;
    logic [31:0]           dev_rdata_reg;

    logic [RegOffsetWidth-1:0] reg_offset;
    logic [31:0]           be_mask, rd_data, src_merged, dst_merged, len_merged;
    logic                  addr_err, wr_en, busy, start;
    logic                  unused_bits;

    assign reg_offset = dev_addr_i[RegOffsetWidth-1:0];
    assign busy       = (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_mask
            assign be_mask[gi*8 +: 8] = {8{dev_be_i[gi]}};
        end
    endgenerate

    assign src_merged = (src_reg & ~be_mask) | (dev_wdata_i & be_mask);
    assign dst_merged = (dst_reg & ~be_mask) | (dev_wdata_i & be_mask);
    assign len_merged = ({{(32-LenWidth){1'b0}}, len_reg} & ~be_mask) | (dev_wdata_i & be_mask);
    assign unused_bits = ^{dev_addr_i[31:RegOffsetWidth], len_merged[31:LenWidth]};

    // Read mux reflects register state before any same-cycle write.
    always_comb begin
        rd_data  = '0;
        addr_err = 1'b0;
        case (reg_offset)
            OFF_SRC:    rd_data = src_reg;
            OFF_DST:    rd_data = dst_reg;
            OFF_LEN:    rd_data = {{(32-LenWidth){1'b0}}, len_reg};
            OFF_CTRL:   rd_data = {30'b0, irq_en_reg, 1'b0};
            OFF_STATUS: rd_data = {29'b0, err_reg, done_reg, busy};
            OFF_REMAIN: rd_data = {{(32-LenWidth){1'b0}}, remain_reg};
            default:    addr_err = 1'b1;
        endcase
    end

    assign wr_en = dev_req_i & dev_we_i & ~addr_err;
    assign start = wr_en && (reg_offset == OFF_CTRL) && dev_be_i[0] && dev_wdata_i[0] && !busy;

    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        dst_next      = dst_reg;
        len_next      = len_reg;
        irq_en_next   = irq_en_reg;
        done_next     = done_reg;
        err_next      = err_reg;
        work_src_next = work_src_reg;
        work_dst_next = work_dst_reg;
        remain_next   = remain_reg;
        data_next     = data_reg;

        if (wr_en) begin
            case (reg_offset)
                OFF_SRC:    if (!busy) src_next = src_merged & 32'hFFFF_FFFC;
                OFF_DST:    if (!busy) dst_next = dst_merged & 32'hFFFF_FFFC;
                OFF_LEN:    if (!busy) len_next = len_merged[LenWidth-1:0];
                OFF_CTRL:   if (dev_be_i[0]) irq_en_next = dev_wdata_i[1];
                OFF_STATUS: begin
                    if (dev_be_i[0] && dev_wdata_i[1]) done_next = 1'b0;
                    if (dev_be_i[0] && dev_wdata_i[2]) err_next  = 1'b0;
                end
                default: ;
            endcase
        end

        if (start) begin
            err_next = 1'b0;
            if (len_reg == '0) begin
                done_next = 1'b1;
            end else begin
                done_next     = 1'b0;
                state_next    = RD_REQ;
                work_src_next = src_reg;
                work_dst_next = dst_reg;
                remain_next   = len_reg;
            end
        end

        // Hardware status updates come after W1C so that a same-cycle set wins.
        case (state_reg)
            RD_REQ:  if (host_gnt_i) state_next = RD_WAIT;
            RD_WAIT: if (host_rvalid_i) begin
                if (host_err_i) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    data_next  = host_rdata_i;
                    state_next = WR_REQ;
                end
            end
            WR_REQ:  if (host_gnt_i) state_next = WR_WAIT;
            WR_WAIT: if (host_rvalid_i) begin
                work_src_next = work_src_reg + 32'd4;
                work_dst_next = work_dst_reg + 32'd4;
                remain_next   = remain_reg - LenWidth'(1);
                if (host_err_i) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (remain_reg == LenWidth'(1)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RD_REQ;
                end
            end
            default: ;
        endcase
    end

    // Host port outputs are registered from the upcoming state so they hold steady while stalled.
    always_comb begin
        host_req_next   = (state_next == RD_REQ) || (state_next == WR_REQ);
        host_we_next    = (state_next == WR_REQ);
        host_addr_next  = host_addr_reg;
        host_wdata_next = host_wdata_reg;
        if (state_next == RD_REQ) begin
            host_addr_next = work_src_next;
        end else if (state_next == WR_REQ) begin
            host_addr_next  = work_dst_next;
            host_wdata_next = data_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            len_reg        <= '0;
            irq_en_reg     <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            work_src_reg   <= '0;
            work_dst_reg   <= '0;
            remain_reg     <= '0;
            data_reg       <= '0;
            host_req_reg   <= 1'b0;
            host_we_reg    <= 1'b0;
            host_addr_reg  <= '0;
            host_wdata_reg <= '0;
            dev_rvalid_reg <= 1'b0;
            dev_rdata_reg  <= '0;
            dev_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            len_reg        <= len_next;
            irq_en_reg     <= irq_en_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            work_src_reg   <= work_src_next;
            work_dst_reg   <= work_dst_next;
            remain_reg     <= remain_next;
            data_reg       <= data_next;
            host_req_reg   <= host_req_next;
            host_we_reg    <= host_we_next;
            host_addr_reg  <= host_addr_next;
            host_wdata_reg <= host_wdata_next;
            dev_rvalid_reg <= dev_req_i;
            dev_rdata_reg  <= (dev_req_i && !dev_we_i) ? rd_data : 32'h0;
            dev_err_reg    <= dev_req_i & addr_err;
        end
    end

    assign dev_rvalid_o = dev_rvalid_reg;
    assign dev_rdata_o  = dev_rdata_reg;
    assign dev_err_o    = dev_err_reg;
    assign host_req_o   = host_req_reg;
    assign host_we_o    = host_we_reg;
    assign host_addr_o  = host_addr_reg;
    assign host_wdata_o = host_wdata_reg;
    assign host_be_o    = 4'hF;
    assign dma_irq_o    = done_reg & irq_en_reg;
endmodule

// File: tb/tb_bus_dma_host.sv
// Bench for bus_dma_host: memory-backed bus responder plus a transfer-level reference model.
module tb_bus_dma_host;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
    logic [3:0]  dev_be_i = 4'h0;
    logic [31:0] dev_addr_i = '0, dev_wdata_i = '0;
    logic        dev_rvalid_o, dev_err_o;
    logic [31:0] dev_rdata_o;
    logic        host_req_o, host_we_o;
    logic        host_gnt_i = 1'b0, host_rvalid_i = 1'b0, host_err_i = 1'b0;
    logic [31:0] host_addr_o, host_wdata_o, host_rdata_i = '0;
    logic [3:0]  host_be_o;
    logic        dma_irq_o;

    bus_dma_host dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
        .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
        .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
        .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
        .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
        .dma_irq_o(dma_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Bus responder: grant after optional stall, answer one cycle after grant.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q[$], wr_addr_q[$], wr_data_q[$];
    bit          ord_q[$];
    bit          pend = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    int          stall_left = 0, err_read_at = 0, rd_count = 0, gnt_count = 0;

    always @(negedge clk_i) begin
        host_rvalid_i = 1'b0;
        host_err_i    = 1'b0;
        host_rdata_i  = '0;
        if (pend) begin
            pend = 1'b0;
            host_rvalid_i = 1'b1;
            ord_q.push_back(p_we);
            if (p_we) begin
                mem[p_addr] = p_wdata;
                wr_addr_q.push_back(p_addr);
                wr_data_q.push_back(p_wdata);
            end else begin
                rd_count++;
                rd_q.push_back(p_addr);
                host_rdata_i = mem.exists(p_addr) ? mem[p_addr] : 32'h0;
                if (rd_count == err_read_at) host_err_i = 1'b1;
            end
        end
        host_gnt_i = 1'b0;
        if (host_req_o === 1'b1) begin
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                host_gnt_i = 1'b1;
                pend = 1'b1;
                p_addr = host_addr_o;
                p_we = host_we_o;
                p_wdata = host_wdata_o;
                gnt_count++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dev_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output logic err);
        @(negedge clk_i);
        dev_req_i = 1'b1; dev_we_i = we; dev_addr_i = addr; dev_wdata_i = wdata; dev_be_i = be;
        @(negedge clk_i);
        dev_req_i = 1'b0; dev_we_i = 1'b0;
        check("dev_rvalid", {31'b0, dev_rvalid_o}, 32'd1);
        rdata = dev_rdata_o;
        err = dev_err_o;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        logic [31:0] d;
        logic e;
        dev_access(1'b1, BASE + off, data, 4'hF, d, e);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        dev_access(1'b0, BASE + off, 32'h0, 4'hF, d, e);
        check(tag, d, exp);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
    endtask

    // Reference view of one transfer.
    logic [31:0] cp_src, cp_dst, src_data[$];
    int          cp_len, cp_stall, cp_err_at, start_cyc;
    bit          cp_irq_en;

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                              input bit irq_en, input int stall, input int err_at);
        logic [31:0] a;
        cp_src = src; cp_dst = dst; cp_len = len; cp_irq_en = irq_en;
        cp_stall = stall; cp_err_at = err_at;
        src_data.delete();
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            mem[a] = $urandom;
            src_data.push_back(mem[a]);
        end
        wr(32'h00, src); wr(32'h04, dst); wr(32'h08, 32'(len));
        rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); ord_q.delete();
        rd_count = 0; err_read_at = err_at; stall_left = stall;
        wr(32'h0C, {30'b0, irq_en, 1'b1});
        start_cyc = cyc;
    endtask

    task automatic finish_copy(input int exp_cycles);
        bit exp_err = (cp_err_at >= 1) && (cp_err_at <= cp_len);
        int n_rd = exp_err ? cp_err_at : cp_len;
        int n_wr = exp_err ? cp_err_at - 1 : cp_len;
        int done_cyc = -1, settle = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c < cp_stall) begin
                check("stall_req", {31'b0, host_req_o}, 32'd1);
                check("stall_addr", host_addr_o, cp_src);
                check("stall_we", {31'b0, host_we_o}, 32'd0);
            end
            if (dma_irq_o === 1'b1 && done_cyc < 0) done_cyc = cyc - start_cyc;
            if (ord_q.size() >= n_rd + n_wr) settle++;
            if (settle >= 3) break;
            @(negedge clk_i);
        end
        check("copy_complete", {31'b0, settle >= 3}, 32'd1);
        if (exp_cycles >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_cycles));
        check("irq_seen", {31'b0, done_cyc >= 0}, {31'b0, cp_irq_en && !exp_err});
        check("n_reads", 32'(rd_q.size()), 32'(n_rd));
        check("n_writes", 32'(wr_addr_q.size()), 32'(n_wr));
        for (int i = 0; i < rd_q.size() && i < n_rd; i++)
            check("rd_addr", rd_q[i], cp_src + 32'(4 * i));
        for (int i = 0; i < wr_addr_q.size() && i < n_wr; i++) begin
            check("wr_addr", wr_addr_q[i], cp_dst + 32'(4 * i));
            check("wr_data", wr_data_q[i], src_data[i]);
            check("dst_mem", mem[cp_dst + 32'(4 * i)], src_data[i]);
        end
        for (int k = 0; k < ord_q.size(); k++)
            check("interleave", {31'b0, ord_q[k]}, {31'b0, k[0]});
        rd_chk("status", 32'h10, exp_err ? 32'h4 : 32'h2);
        rd_chk("remain", 32'h14, 32'(cp_len - n_wr));
        rd_chk("src_kept", 32'h00, cp_src);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] m_src, m_dst, m_len, d, exp, offs, data;
        logic [3:0]  be;
        logic        e;
        int          sel, len, gnt_before, err_at;

        repeat (3) @(negedge clk_i);
        check("rst_host_req", {31'b0, host_req_o}, 32'd0);
        check("rst_host_we", {31'b0, host_we_o}, 32'd0);
        check("rst_host_addr", host_addr_o, 32'h0);
        check("rst_host_wdata", host_wdata_o, 32'h0);
        check("rst_host_be", {28'b0, host_be_o}, 32'hF);
        check("rst_dev_rvalid", {31'b0, dev_rvalid_o}, 32'd0);
        check("rst_dev_rdata", dev_rdata_o, 32'h0);
        check("rst_dev_err", {31'b0, dev_err_o}, 32'd0);
        check("rst_irq", {31'b0, dma_irq_o}, 32'd0);
        rst_ni = 1'b1;

        // Byte-enable writes against a per-byte merge model.
        m_src = 0; m_dst = 0; m_len = 0;
        for (int it = 0; it < 8; it++) begin
            sel = $urandom_range(0, 2);
            be = 4'($urandom_range(0, 15));
            data = $urandom;
            offs = 32'(4 * sel);
            exp = (sel == 0) ? m_src : (sel == 1) ? m_dst : m_len;
            for (int b = 0; b < 4; b++) if (be[b]) exp[8*b +: 8] = data[8*b +: 8];
            if (sel == 2) exp = exp & 32'h0000_FFFF; else exp = exp & 32'hFFFF_FFFC;
            if (sel == 0) m_src = exp; else if (sel == 1) m_dst = exp; else m_len = exp;
            dev_access(1'b1, BASE + offs, data, be, d, e);
            check("be_wr_err", {31'b0, e}, 32'd0);
            rd_chk("be_readback", offs, exp);
        end

        // Basic copy, then stalled first grant.
        start_copy(32'h0010_0000, 32'h0010_0400, 4, 1'b1, 0, 0);
        finish_copy(16);
        check("irq_after_copy", {31'b0, dma_irq_o}, 32'd1);
        start_copy(32'h0011_0000, 32'h0011_0400, 4, 1'b1, 5, 0);
        finish_copy(21);

        // Read error on second word.
        start_copy(32'h0012_0000, 32'h0012_0400, 3, 1'b0, 0, 2);
        finish_copy(-1);
        check("err_irq_low", {31'b0, dma_irq_o}, 32'd0);

        // Zero-length start and W1C of done.
        wr(32'h08, 32'h0);
        gnt_before = gnt_count;
        wr(32'h0C, 32'h3);
        check("len0_irq_next", {31'b0, dma_irq_o}, 32'd1);
        repeat (4) @(negedge clk_i);
        check("len0_no_bus", 32'(gnt_count), 32'(gnt_before));
        rd_chk("len0_status", 32'h10, 32'h2);
        wr(32'h10, 32'h2);
        check("w1c_irq_drop", {31'b0, dma_irq_o}, 32'd0);
        rd_chk("w1c_status", 32'h10, 32'h0);

        // Writes and restart while busy are ignored.
        start_copy(32'h0013_0000, 32'h0013_0400, 4, 1'b0, 0, 0);
        wr(32'h00, 32'hDEAD_0000);
        wr(32'h0C, 32'h1);
        rd_chk("busy_status", 32'h10, 32'h1);
        finish_copy(-1);
        dev_access(1'b0, BASE + 32'h20, 32'h0, 4'hF, d, e);
        check("bad_off_err", {31'b0, e}, 32'd1);
        check("bad_off_rdata", d, 32'h0);

        // Source address wraps past 2^32.
        start_copy(32'hFFFF_FFFC, 32'h0014_0000, 2, 1'b1, 0, 0);
        finish_copy(8);
        if (rd_q.size() > 1) check("wrap_addr", rd_q[1], 32'h0);

        // Randomized transfers.
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 8);
            err_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            sel = $urandom_range(0, 3);
            start_copy(32'h0020_0000 + 32'($urandom_range(0, 255)) * 64,
                       32'h0040_0000 + 32'($urandom_range(0, 255)) * 64,
                       len, 1'($urandom_range(0, 1)), sel, err_at);
            finish_copy((err_at == 0 && cp_irq_en) ? 4 * len + sel : -1);
        end

        // Asynchronous reset mid-transfer, with a late response after release.
        start_copy(32'h0015_0000, 32'h0015_0400, 8, 1'b1, 0, 0);
        check("pre_rst_req", {31'b0, host_req_o}, 32'd1);
        #1 rst_ni = 1'b0;
        #1 check("async_rst_req", {31'b0, host_req_o}, 32'd0);
        #1 rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check("post_rst_req", {31'b0, host_req_o}, 32'd0);
        rd_chk("post_rst_src", 32'h00, 32'h0);
        rd_chk("post_rst_dst", 32'h04, 32'h0);
        rd_chk("post_rst_len", 32'h08, 32'h0);
        rd_chk("post_rst_ctrl", 32'h0C, 32'h0);
        rd_chk("post_rst_status", 32'h10, 32'h0);
        rd_chk("post_rst_remain", 32'h14, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
